// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch sequencer between the pointer register and a synchronous instruction RAM
//   Clk        rising-edge clock
//   RST        synchronous active-high reset
//   fetch_req  control unit requests the next instruction
//   flush      cancel any in-flight fetch or held instruction
//   addr_in    current pointer value, used as the fetch address
//   mem_addr   registered RAM address
//   mem_re     one-cycle RAM read enable
//   mem_rdata  RAM read data, valid MEM_LAT clocks after the address is presented
//   ir_out     instruction register (qualified by ir_valid)
//   ir_valid   ir_out holds an unconsumed instruction
//   ir_ready   control unit accepts ir_out
//   inc_out    one-cycle pulse that advances the pointer
//   busy       sequencer is not idle
module instr_fetch_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              Clk,
  input  logic              RST,
  input  logic              fetch_req,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              inc_out,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  localparam logic [2:0] LAT = 3'(MEM_LAT);
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] ir_n;
  logic re_n, valid_n, inc_n, issue;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = mem_addr;
    ir_n    = ir_out;
    valid_n = ir_valid;
    re_n    = 1'b0;
    inc_n   = 1'b0;
    // a new read starts from IDLE, or straight out of HOLD on the accepting edge
    issue   = fetch_req && !flush && (state == IDLE || (state == HOLD && ir_ready));
    case (state)
      WAIT: begin
        cnt_n = cnt != 3'd0 ? cnt - 3'd1 : cnt;
        // counter reaching zero marks the edge where the RAM word is on mem_rdata
        if (flush) state_n = IDLE;
        else if (cnt == 3'd0) begin
          ir_n    = mem_rdata;
          valid_n = 1'b1;
          inc_n   = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (flush || ir_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: ;
    endcase
    if (issue) begin
      addr_n  = addr_in;
      re_n    = 1'b1;
      cnt_n   = LAT;
      state_n = WAIT;
    end
  end
  always_ff @(posedge Clk) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      mem_addr <= '0;
      mem_re   <= 1'b0;
      ir_out   <= '0;
      ir_valid <= 1'b0;
      inc_out  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      mem_addr <= addr_n;
      mem_re   <= re_n;
      ir_out   <= ir_n;
      ir_valid <= valid_n;
      inc_out  <= inc_n;
      busy     <= state_n != IDLE;
    end
  end
endmodule
